// File: rtl/complex_result_drain_pkg.sv
// Shared definitions for the convolution result drain: FSM encoding and the
// default word width / frame length used across the convolution datapath.
package complex_result_drain_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int FRAME_LEN_DEF = 100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/complex_result_drain_if.sv
// Control, sample input and valid/ready output stream of the result drain.
interface complex_result_drain_if
    import complex_result_drain_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] result_r;
    logic [DATA_W-1:0] result_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_r;
    logic [DATA_W-1:0] out_i;
    logic              out_last;
    logic              frame_done;
    logic              overflow;
    logic              busy;

    modport master (
        output start, in_valid, result_r, result_i, out_ready,
        input  out_valid, out_r, out_i, out_last, frame_done, overflow, busy
    );

    modport slave (
        input  start, in_valid, result_r, result_i, out_ready,
        output out_valid, out_r, out_i, out_last, frame_done, overflow, busy
    );

endinterface

// File: rtl/complex_result_drain_fifo.sv
// Show-ahead synchronous FIFO; the caller guarantees push only when there is
// room (or a pop in the same cycle) and pop only when non-empty.
module sync_fifo_showahead #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers and occupancy define contents.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/complex_result_drain.sv
// Frames FRAME_LEN convolution results after SKIP fill samples and drains them
// through a show-ahead FIFO onto a valid/ready stream with a last marker.
module complex_result_drain
    import complex_result_drain_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int SKIP      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    complex_result_drain_if.slave  bus
);

    localparam int FW = 2*DATA_W + 1;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;

    state_e        state_q, state_d;
    logic [SW-1:0] skip_cnt_q, skip_cnt_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          overflow_q, overflow_d;

    logic          push, pop, full, empty, last;
    logic [FW-1:0] head;

    assign pop  = !empty && bus.out_ready;
    assign last = (frame_cnt_q == CW'(FRAME_LEN-1));

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;
        push        = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                skip_cnt_d  = '0;
                frame_cnt_d = '0;
                overflow_d  = 1'b0;
                state_d     = (SKIP == 0) ? ST_CAPTURE : ST_FLUSH;
            end
            ST_FLUSH: if (bus.in_valid) begin
                skip_cnt_d = skip_cnt_q + 1'b1;
                if (skip_cnt_q == SW'(SKIP-1)) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: if (bus.in_valid) begin
                // A full FIFO still takes the sample if the head leaves this cycle.
                push        = !full || pop;
                overflow_d  = overflow_q || !push;
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (last) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            skip_cnt_q  <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo_showahead #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({last, bus.result_r, bus.result_i}),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // Head fields are zeroed while empty so stale storage never shows.
    assign bus.out_valid  = !empty;
    assign bus.out_last   = !empty && head[FW-1];
    assign bus.out_r      = empty ? '0 : head[2*DATA_W-1:DATA_W];
    assign bus.out_i      = empty ? '0 : head[DATA_W-1:0];
    assign bus.frame_done = (state_q == ST_DONE);
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_complex_result_drain.sv
// Scoreboard bench: stimulus queues expected words and scalar checks, a single
// monitor process on the falling edge performs every comparison.
module tb_complex_result_drain;
    import complex_result_drain_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int FL    = 100;
    localparam int SKIP  = 3;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] r;
        logic [DW-1:0] i;
    } ent_t;

    typedef struct {
        string  nm;
        longint act;
        longint exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    complex_result_drain_if #(.DATA_W(DW)) bus ();

    complex_result_drain #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FL),
        .SKIP      (SKIP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t sb[$];
    chk_t chk_q[$];
    int n_tests = 0, n_fail = 0;
    int pops = 0, lasts = 0, dones = 0, cyc_n = 0, last_pop_cyc = 0;

    // Monitor: the only process that compares and counts.
    initial begin
        chk_t c;
        ent_t e;
        ent_t got;
        forever begin
            @(negedge clk);
            cyc_n++;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_tests++;
                if (c.act != c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", c.nm, c.act, c.exp);
                end
            end
            if (!rst && bus.out_valid && bus.out_ready) begin
                n_tests++;
                got = {bus.out_last, bus.out_r, bus.out_i};
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got r=0x%0h i=0x%0h last=%0d, scoreboard empty",
                             bus.out_r, bus.out_i, bus.out_last);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL word: got r=0x%0h i=0x%0h last=%0d expected r=0x%0h i=0x%0h last=%0d",
                                 got.r, got.i, got.last, e.r, e.i, e.last);
                    end
                end
                pops++;
                if (bus.out_last) lasts++;
                last_pop_cyc = cyc_n;
            end
            if (!rst && bus.frame_done) begin
                dones++;
                n_tests++;
                if (cyc_n - last_pop_cyc != 2) begin
                    n_fail++;
                    $display("FAIL done_latency: got %0d cycles after last pop expected 2",
                             cyc_n - last_pop_cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint a, input longint e);
        chk_q.push_back('{nm, a, e});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] i);
        bus.in_valid = v;
        bus.result_r = r;
        bus.result_i = i;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic smp(input logic [DW-1:0] r, input logic [DW-1:0] i, input bit acc, input bit last);
        if (acc) sb.push_back('{last, r, i});
        drv(1'b1, r, i);
    endtask

    task automatic go();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic flush_fill();
        for (int k = 0; k < SKIP; k++) drv(1'b1, 32'hF000_0000 + k, 32'h0F00_0000 + k);
    endtask

    task automatic wait_done(input string nm);
        int  d0;
        bit  got;
        d0  = dones;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            #1;
            if (dones > d0) got = 1'b1;
        end
        chk({nm, "_done_seen"}, got, 1);
        cyc();
        cyc();
        chk({nm, "_done_once"}, dones - d0, 1);
        chk({nm, "_idle"}, bus.busy, 0);
        chk({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int p0, l0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.result_r  = '0;
        bus.result_i  = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_r", bus.out_r, 0);
        chk("rst_out_i", bus.out_i, 0);

        // 1: basic frame, n=0..102, first SKIP discarded; stray start mid-frame.
        bus.out_ready = 1'b1;
        p0 = pops; l0 = lasts;
        go();
        chk("t1_busy", bus.busy, 1);
        for (int n = 0; n < FL + SKIP; n++) begin
            if (n == 50) bus.start = 1'b1;
            smp(n, 32'(-n), n >= SKIP, n == FL + SKIP - 1);
            bus.start = 1'b0;
        end
        chk("t1_overflow", bus.overflow, 0);
        wait_done("t1");
        chk("t1_pops", pops - p0, FL);
        chk("t1_lasts", lasts - l0, 1);

        // 2: no downstream during capture; only the first DEPTH samples survive.
        bus.out_ready = 1'b0;
        p0 = pops; l0 = lasts;
        go();
        flush_fill();
        for (int k = 0; k < FL; k++) begin
            smp(1000 + k, 2000 + k, k < DEPTH, k == FL - 1);
            if (k == DEPTH - 1) chk("t2_ovf_before", bus.overflow, 0);
            if (k == DEPTH)     chk("t2_ovf_after", bus.overflow, 1);
        end
        chk("t2_head_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        wait_done("t2");
        chk("t2_pops", pops - p0, DEPTH);
        chk("t2_lasts", lasts - l0, 0);
        chk("t2_ovf_sticky", bus.overflow, 1);

        // 3: full FIFO with a pop in the same cycle still accepts the push.
        bus.out_ready = 1'b0;
        p0 = pops; l0 = lasts;
        go();
        chk("t3_ovf_cleared", bus.overflow, 0);
        flush_fill();
        for (int k = 0; k < DEPTH; k++) smp(4000 + k, k, 1, 0);
        chk("t3_ovf_full", bus.overflow, 0);
        bus.out_ready = 1'b1;
        smp(4000 + DEPTH, DEPTH, 1, 0);
        bus.out_ready = 1'b0;
        chk("t3_ovf_simul", bus.overflow, 0);
        smp(4000 + DEPTH + 1, DEPTH + 1, 0, 0);
        chk("t3_still_full", bus.overflow, 1);
        bus.out_ready = 1'b1;
        for (int k = DEPTH + 2; k < FL; k++) smp(4000 + k, k, 1, k == FL - 1);
        wait_done("t3");
        chk("t3_pops", pops - p0, FL - 1);
        chk("t3_lasts", lasts - l0, 1);

        // 4: gapped input; idle cycles carry junk and must not count.
        bus.out_ready = 1'b1;
        p0 = pops; l0 = lasts;
        go();
        for (int n = 0; n < FL + SKIP; n++) begin
            if (n == FL + SKIP - 1) chk("t4_busy_before_last", bus.busy, 1);
            smp(500 + n, n, n >= SKIP, n == FL + SKIP - 1);
            drv(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        end
        wait_done("t4");
        chk("t4_pops", pops - p0, FL);
        chk("t4_lasts", lasts - l0, 1);
        chk("t4_overflow", bus.overflow, 0);

        // 5: stalled head held stable.
        bus.out_ready = 1'b0;
        p0 = pops;
        go();
        flush_fill();
        smp(32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valid", bus.out_valid, 1);
            chk("t5_hold_r", bus.out_r, 32'h1234_5678);
            chk("t5_hold_i", bus.out_i, 32'h9ABC_DEF0);
            cyc();
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < FL; k++) smp(k, k, 1, k == FL - 1);
        wait_done("t5");
        chk("t5_pops", pops - p0, FL);

        // 6: reset mid-capture with 8 words buffered; start alongside rst is ignored.
        bus.out_ready = 1'b1;
        go();
        flush_fill();
        for (int k = 0; k < 40; k++) begin
            if (k == 33) bus.out_ready = 1'b0;
            smp(3000 + k, k, 1, 0);
        end
        chk("t6_buffered", sb.size(), 8);
        bus.start = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.start = 1'b0;
        sb.delete();
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_overflow", bus.overflow, 0);
        cyc();
        chk("t6_start_ignored", bus.busy, 0);
        bus.out_ready = 1'b1;
        p0 = pops; l0 = lasts;
        go();
        flush_fill();
        for (int k = 0; k < FL; k++) smp(7000 + k, 32'(~k), 1, k == FL - 1);
        wait_done("t6");
        chk("t6_pops", pops - p0, FL);
        chk("t6_lasts", lasts - l0, 1);

        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/complex_result_drain.md
Name: complex_result_drain

Overview:
- Sink at the output end of the complex convolution datapath.
- Accepts one complex result (result_r, result_i) per clock, discards the pipeline-fill samples, and frames exactly FRAME_LEN results.
- Buffers results in a small FIFO and presents them downstream on a valid/ready stream with a last marker, so a checker or packer can read a full frame at its own pace.

Parameters:
- DATA_W, 32, width of each real/imag result word.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- FRAME_LEN, 100, accepted results per frame.
- SKIP, 3, leading in_valid samples discarded after start (convolution fill latency); 0 allowed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; arms a new frame; ignored unless state is IDLE.
- in_valid  in  1  result_r/result_i valid this cycle.
- result_r  in  DATA_W  real part of the convolution result.
- result_i  in  DATA_W  imaginary part of the convolution result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_r  out  DATA_W  head real word.
- out_i  out  DATA_W  head imaginary word.
- out_last  out  1  head is the FRAME_LEN-th sample of the frame.
- frame_done  out  1  one-cycle pulse when the frame is fully drained.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: state IDLE, FIFO empty, all counters 0. Outputs out_valid, out_last, frame_done, overflow and busy are 0; out_r and out_i are 0. Reset mid-frame discards all FIFO contents immediately.
- FSM states are IDLE, FLUSH, CAPTURE, DRAIN, DONE.
- IDLE: in_valid is ignored. On start, go to FLUSH and clear overflow and the counters. If SKIP==0, go directly to CAPTURE.
- FLUSH: each in_valid increments skip_cnt and the sample is discarded. When the SKIP-th valid sample is discarded, go to CAPTURE on the next cycle.
- CAPTURE: each in_valid is a frame sample and increments frame_cnt from 0 to FRAME_LEN-1.
  - Push condition: (not full) OR (full AND out_valid AND out_ready in the same cycle).
  - The entry stores {last, r, i}, with last = (frame_cnt == FRAME_LEN-1).
  - If a sample cannot be pushed, it is dropped, overflow is set, and frame_cnt still advances. The frame is defined in input time.
  - After the FRAME_LEN-th valid sample, go to DRAIN.
- DRAIN: in_valid is ignored. When the FIFO is empty (after the final pop), go to DONE.
- DONE: frame_done = 1 for exactly one cycle, then go to IDLE.
- FIFO timing:
  - Show-ahead. out_r, out_i and out_last present mem[rd_ptr] whenever out_valid=1.
  - Write-to-out_valid latency is 1 cycle: a push at edge k gives out_valid=1 after edge k.
  - Pop happens when out_valid && out_ready.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty is distinguished by an occupancy counter of width log2(DEPTH)+1.
  - A simultaneous push and pop when empty is impossible (out_valid=0). A simultaneous push and pop when full leaves occupancy unchanged.
- Output stability: out_r, out_i and out_last are held stable while out_valid && !out_ready.
- Dropped last sample: if the last sample is dropped, no entry carries out_last. frame_done still pulses after the FIFO empties.
- start outside IDLE has no effect. start in the same cycle as rst is ignored (reset wins).
- Data is passed bit-exact; there is no arithmetic on samples.

Decomposition:
- Shared package holds:
  - the FSM state encoding constants: IDLE=0, FLUSH=1, CAPTURE=2, DRAIN=3, DONE=4 (3-bit);
  - the default DATA_W and FRAME_LEN, shared with the convolution core and its bench.
- One sub-module: sync_fifo_showahead, parameterised on width (2*DATA_W+1) and DEPTH, exposing push, pop, full, empty, head.
- The FSM and counters stay in the top.

Test Plan:
1. Basic frame: SKIP=3, FRAME_LEN=100, out_ready=1, start, then 103 consecutive valid samples with result_r=n, result_i=-n for n=0..102. Required: outputs r=3..102 in order, one cycle after each push; out_last only on r=102; frame_done one cycle after the last pop; overflow=0.
2. Backpressure overflow: DEPTH=16, out_ready=0 throughout capture, 100 samples. Required: the first 16 samples are retained; overflow=1 from the 17th sample on. After out_ready=1, exactly 16 words drain, none with out_last, then frame_done pulses.
3. Full plus simultaneous pop: fill the FIFO to 16 entries, then assert out_ready and in_valid in the same cycle. Required: the push is accepted, occupancy stays 16, and overflow stays 0.
4. Gapped input: in_valid toggles 1,0,1,0. Required: only valid cycles are counted, and the frame ends after 100 valid samples plus SKIP.
5. Stall hold: out_ready=0 for 5 cycles with a head of r=0x12345678. Required: out_r stays 0x12345678 and out_valid stays 1 for all 5 cycles.
6. Reset mid-CAPTURE: assert rst after 40 samples with 8 words buffered. Required: the next cycle shows out_valid=0, busy=0 and overflow=0; a new start yields a fresh 100-sample frame.
